// File: rtl/gvp_stream_packer.sv
// gvp_stream_packer: captures GVP store events into a 2-deep snapshot FIFO
// and serializes each one as a framed 32-bit AXI4-Stream packet, stalling
// the GVP core whenever a snapshot is waiting behind the active packet.
module gvp_stream_packer #(
  parameter int WORDS_HDR = 11,
  parameter int WORDS_PT  = 10
) (
  input  logic        a_clk,
  input  logic        a_resetn,
  input  logic [1:0]  store_data,
  input  logic        store_tick,
  input  logic [31:0] vec_x,
  input  logic [31:0] vec_y,
  input  logic [31:0] vec_z,
  input  logic [31:0] vec_u,
  input  logic [31:0] vec_a,
  input  logic [31:0] vec_b,
  input  logic [31:0] srcs,
  input  logic [31:0] index,
  input  logic [47:0] gvp_time,
  output logic [31:0] M_AXIS_tdata,
  output logic        M_AXIS_tvalid,
  input  logic        M_AXIS_tready,
  output logic        M_AXIS_tlast,
  output logic        stall,
  output logic [15:0] drop_count,
  output logic        busy
);

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] srcs;
    logic [31:0] idx;
    logic [47:0] tim;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] u;
    logic [31:0] a;
    logic [31:0] b;
  } snap_t;

  typedef enum logic {IDLE, SEND} state_t;

  snap_t       fifoMem_q [2];
  logic        wrPtr_q;
  logic        rdPtr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        stall_q;
  logic [15:0] dropCnt_q;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  wordCnt_q;
  logic [3:0]  wordCnt_d;
  logic [3:0]  lastIdx_q;
  logic [31:0] words_q   [WORDS_HDR];
  logic [31:0] loadWords [WORDS_HDR];

  snap_t snapIn;
  snap_t head;
  logic  storeReq;
  logic  push;
  logic  pop;
  logic  handshake;

  assign snapIn = '{code: store_data, srcs: srcs, idx: index, tim: gvp_time,
                    x: vec_x, y: vec_y, z: vec_z, u: vec_u, a: vec_a, b: vec_b};
  assign storeReq  = store_tick && (store_data != 2'd0);
  assign pop       = (state_q == IDLE) && (count_q != 2'd0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push      = storeReq && ((count_q != 2'd2) || pop);
  assign head      = fifoMem_q[rdPtr_q];
  assign handshake = (state_q == SEND) && M_AXIS_tready;

  // Occupancy after this cycle's push and pop; also drives the registered stall.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Snapshot FIFO storage, pointers, stall flag and saturating drop counter.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      count_q      <= 2'd0;
      stall_q      <= 1'b0;
      dropCnt_q    <= 16'd0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= snapIn;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
      stall_q <= (count_d != 2'd0);
      if (storeReq && !push && (dropCnt_q != 16'hFFFF)) begin
        dropCnt_q <= dropCnt_q + 16'd1;
      end
    end
  end

  // Lay out the packet words of the FIFO head according to its store code.
  always_comb begin
    for (int i = 0; i < WORDS_HDR; i++) begin
      loadWords[i] = '0;
    end
    if (head.code == 2'd1) begin
      loadWords[0] = 32'hDA7A_0001;
      loadWords[1] = head.idx;
      loadWords[2] = head.tim[31:0];
      loadWords[3] = {16'h0, head.tim[47:32]};
      loadWords[4] = head.x;
      loadWords[5] = head.y;
      loadWords[6] = head.z;
      loadWords[7] = head.u;
      loadWords[8] = head.a;
      loadWords[9] = head.b;
    end else begin
      loadWords[0]  = {16'hFEED, 14'h0, head.code};
      loadWords[1]  = head.srcs;
      loadWords[2]  = head.idx;
      loadWords[3]  = head.tim[31:0];
      loadWords[4]  = {16'h0, head.tim[47:32]};
      loadWords[5]  = head.x;
      loadWords[6]  = head.y;
      loadWords[7]  = head.z;
      loadWords[8]  = head.u;
      loadWords[9]  = head.a;
      loadWords[10] = head.b;
    end
  end

  // Serializer next-state: pop when idle, advance one word per handshake.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
    case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          state_d   = SEND;
          wordCnt_d = 4'd0;
        end
      end
      SEND: begin
        if (M_AXIS_tready) begin
          if (wordCnt_q == lastIdx_q) begin
            state_d   = IDLE;
            wordCnt_d = 4'd0;
          end else begin
            wordCnt_d = wordCnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        wordCnt_d = 4'd0;
      end
    endcase
  end

  // Serializer state register and word counter.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q   <= IDLE;
      wordCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
    end
  end

  // Packet shift register: loaded on pop, shifted toward word 0 on each handshake.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      for (int i = 0; i < WORDS_HDR; i++) begin
        words_q[i] <= '0;
      end
      lastIdx_q <= 4'd0;
    end else if (pop) begin
      for (int i = 0; i < WORDS_HDR; i++) begin
        words_q[i] <= loadWords[i];
      end
      lastIdx_q <= (head.code == 2'd1) ? 4'(WORDS_PT - 1) : 4'(WORDS_HDR - 1);
    end else if (handshake) begin
      for (int i = 0; i < WORDS_HDR - 1; i++) begin
        words_q[i] <= words_q[i + 1];
      end
      words_q[WORDS_HDR - 1] <= '0;
    end
  end

  assign M_AXIS_tvalid = (state_q == SEND);
  assign M_AXIS_tdata  = M_AXIS_tvalid ? words_q[0] : 32'd0;
  assign M_AXIS_tlast  = M_AXIS_tvalid && (wordCnt_q == lastIdx_q);
  assign stall         = stall_q;
  assign drop_count    = dropCnt_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/gvp_stream_packer.md
# gvp_stream_packer

Serializes GVP store events into one 32-bit AXI4-Stream for the DMA path. It snapshots the vector outputs (X,Y,Z,U,A,B), source options, index and GVP time whenever the GVP core signals a store. It then emits a framed packet per event. It back-pressures the GVP core through `stall` so that no event is lost while the stream is blocked.

## Interface
- `WORDS_HDR`, 11: words in a header or end packet.
- `WORDS_PT`, 10: words in a data-point packet.
- `a_clk`  in  1  system clock (120 MHz).
- `a_resetn`  in  1  reset, asynchronous, active-low.
- `store_data`  in  2  GVP store code: 0 none, 1 point, 2 section header, 3 end of program.
- `store_tick`  in  1  one-cycle strobe marking the cycle in which `store_data` and the vector values are valid; only sampled when high.
- `vec_x`, `vec_y`, `vec_z`, `vec_u`, `vec_a`, `vec_b`  in  32 each  GVP vector components.
- `srcs`  in  32  section options / source bits.
- `index`  in  32  GVP point index.
- `gvp_time`  in  48  GVP time counter.
- `M_AXIS_tdata`  out  32  stream data.
- `M_AXIS_tvalid`  out  1
- `M_AXIS_tready`  in  1
- `M_AXIS_tlast`  out  1  high on the last word of each packet.
- `stall`  out  1  to the GVP core `stall` input.
- `drop_count`  out  16  saturating count of events lost on overflow.
- `busy`  out  1  high while the serializer is not in IDLE.

## Operation
- **Capture.** On a cycle with `store_tick`=1 and `store_data`≠0, write a snapshot {code, srcs, index, time, x..b} into a 2-entry snapshot FIFO.
  - If the FIFO is full, discard the snapshot and increment `drop_count`, saturating at 0xFFFF.
  - `store_tick`=1 with `store_data`=0 is ignored.
- **Serializer FSM.**
  - IDLE: when the FIFO is non-empty, pop the head into the shift registers and go to SEND with word counter=0.
  - SEND: present word[counter]. On `tvalid`&&`tready`, increment the counter.
  - On handshake of the last word, go to IDLE. The next pop happens no earlier than the following cycle.
- **Header packet (code 2), 11 words:** 0xFEED_0002, srcs, index, time[31:0], {16'h0, time[47:32]}, x, y, z, u, a, b.
- **End packet (code 3):** same layout as the header packet; word0 is 0xFEED_0003.
- **Point packet (code 1), 10 words:** 0xDA7A_0001, index, time[31:0], {16'h0, time[47:32]}, x, y, z, u, a, b.
- **tlast:** high exactly on the final word of each packet (word 10 for header/end, word 9 for point).
- **stall:** registered `stall` = (FIFO occupancy after this cycle's push/pop ≥ 1). It is therefore high while any snapshot waits behind the active packet, and low when the FIFO is empty.
- **Snapshot values** are the exact input values in the tick cycle. Later input changes never alter a queued or in-flight packet.
- **Simultaneous push and pop** on the same cycle: both take effect, occupancy is unchanged, and the push is accepted even when occupancy is 2, because the pop frees a slot first.

## Timing
- **Reset values:** `M_AXIS_tvalid`=0, `M_AXIS_tdata`=0, `M_AXIS_tlast`=0, `stall`=0, `drop_count`=0, `busy`=0. The FIFO is empty and the FSM is in IDLE.
- **Reset during a packet:** the packet is truncated, `tvalid` drops immediately (asynchronously), and no partial packet is resumed after reset.
- **Latency:** tick at cycle t → snapshot in FIFO at t+1 → word0 with `tvalid`=1 at t+2, given an empty FIFO and an IDLE FSM.
- **Minimum packet duration** is WORDS cycles with `tready` held high. There is one IDLE cycle between back-to-back packets.
- **AXI-Stream rules:** once `tvalid` is high, `tdata`/`tlast` stay stable and `tvalid` stays high until `tready`. `tvalid` never depends combinationally on `tready`.
- **stall timing:** `stall` rises the cycle after the push that makes occupancy ≥1, and falls the cycle after the pop that empties the FIFO.

## Test plan
- **Single point:** `store_tick` with code 1, index=5, time=0x1_0000_0002, x=0x10, `tready`=1.
  - Expect 10 words starting 0xDA7A_0001, 5, 0x00000002, 0x00000001, 0x10.
  - `tlast` on word 9; first `tvalid` 2 cycles after the tick.
- **Header then end:** code 2, then 20 cycles later code 3.
  - Expect two 11-word packets with word0 0xFEED_0002 and 0xFEED_0003, and srcs in word1.
- **Back-pressure:** `tready` toggles 1,0,0,1… through a point packet.
  - `tdata` is held constant during low-`tready` cycles; all 10 words are delivered in order with no duplicates.
- **Overflow:** `tready`=0, 4 ticks with code 1.
  - First snapshot goes into the serializer, 2 are queued, 1 is dropped: `drop_count`=1.
  - `stall` is high from the cycle after the second tick.
  - After `tready`=1, exactly 3 packets are sent and `stall` returns to 0.
- **Snapshot integrity:** change `vec_x` every cycle after the tick.
  - The packet carries the tick-cycle value.
- **Async reset mid-packet:** assert `a_resetn`=0 at word 4.
  - `tvalid`=0 immediately, `drop_count`=0.
  - After release, a new tick produces a complete packet starting at word0.
